// File: rtl/perceptron_learn_pkg.sv
// Shared definitions for the perceptron learning block: FSM states and
// default parameter values.
package perceptron_learn_pkg;

  localparam int N_DEFAULT      = 8;
  localparam int WW_DEFAULT     = 8;
  localparam int W_INIT_DEFAULT = 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DECIDE,
    UPDATE
  } state_t;

endpackage

// File: rtl/perceptron_learn_sat_addsub.sv
// Signed WW-bit add/subtract of an unsigned step with clamping to the
// signed WW range; used for the weight update.
module sat_addsub #(
  parameter int WW = 8
) (
  input  logic signed [WW-1:0] a,
  input  logic        [WW-2:0] b,
  input  logic                 sub,
  output logic signed [WW-1:0] y
);

  logic [WW:0] wide;

  // One guard bit is enough: a differing top pair means overflow.
  always_comb begin
    if (sub) begin
      wide = {a[WW-1], a} - {2'b00, b};
    end else begin
      wide = {a[WW-1], a} + {2'b00, b};
    end
    if (wide[WW] != wide[WW-1]) begin
      y = wide[WW] ? {1'b1, {(WW-1){1'b0}}} : {1'b0, {(WW-1){1'b1}}};
    end else begin
      y = wide[WW-1:0];
    end
  end

endmodule

// File: rtl/perceptron_learn.sv
// Serial perceptron: accumulates one weight per cycle, classifies against a
// threshold and, for misclassified training samples, adjusts the weights.
module perceptron_learn
  import perceptron_learn_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int WW     = WW_DEFAULT,
  parameter int AW     = WW + $clog2(N) + 1,
  parameter int W_INIT = W_INIT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               x,
  input  logic signed [AW-1:0]       threshold,
  input  logic                       train_en,
  input  logic                       target,
  input  logic [WW-2:0]              rate,
  input  logic                       w_load,
  input  logic [$clog2(N)-1:0]       w_idx,
  input  logic [WW-1:0]              w_data,
  output logic                       out_valid,
  output logic                       result,
  output logic signed [AW-1:0]       net,
  output logic                       busy
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t                state_q, state_d;
  logic [N-1:0]          x_q, x_d;
  logic signed [AW-1:0]  thr_q, thr_d;
  logic                  train_q, train_d;
  logic                  target_q, target_d;
  logic [WW-2:0]         rate_q, rate_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  out_valid_q, out_valid_d;
  logic                  result_q, result_d;
  logic signed [AW-1:0]  net_q, net_d;
  logic signed [WW-1:0]  w_q [N];
  logic signed [WW-1:0]  w_d [N];

  logic signed [WW-1:0]  w_cur;
  logic signed [WW-1:0]  w_upd;
  logic signed [AW-1:0]  acc_sum;

  assign w_cur = w_q[idx_q];

  sat_addsub #(.WW(WW)) u_sat (
    .a   (w_cur),
    .b   (rate_q),
    .sub (!target_q),
    .y   (w_upd)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    thr_d       = thr_q;
    train_d     = train_q;
    target_d    = target_q;
    rate_d      = rate_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    net_d       = net_q;
    w_d         = w_q;
    acc_sum     = acc_q + (x_q[idx_q] ? {{(AW-WW){w_cur[WW-1]}}, w_cur} : '0);

    case (state_q)
      IDLE: begin
        // A host weight write takes priority and blocks sample acceptance.
        if (w_load) begin
          if (int'(w_idx) < N) begin
            w_d[w_idx] = w_data;
          end
        end else if (in_valid) begin
          x_d      = x;
          thr_d    = threshold;
          train_d  = train_en;
          target_d = target;
          rate_d   = rate;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_sum;
        idx_d = idx_q + IW'(1);
        // Outputs register on the final term so the pulse coincides with DECIDE.
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          out_valid_d = 1'b1;
          net_d       = acc_sum;
          result_d    = (acc_sum >= thr_q);
          state_d     = DECIDE;
        end
      end
      DECIDE: begin
        idx_d   = '0;
        state_d = (train_q && (result_q != target_q)) ? UPDATE : IDLE;
      end
      UPDATE: begin
        if (x_q[idx_q]) begin
          w_d[idx_q] = w_upd;
        end
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      thr_q       <= '0;
      train_q     <= 1'b0;
      target_q    <= 1'b0;
      rate_q      <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= 1'b0;
      net_q       <= '0;
      for (int i = 0; i < N; i++) begin
        w_q[i] <= WW'(W_INIT);
      end
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      thr_q       <= thr_d;
      train_q     <= train_d;
      target_q    <= target_d;
      rate_q      <= rate_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      net_q       <= net_d;
      w_q         <= w_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !w_load;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign net       = net_q;

endmodule

// File: tb/tb_perceptron_learn.sv
// Scoreboard bench for perceptron_learn: a weight-array model predicts each
// classification; a monitor checks every out_valid pulse against the queue.
module tb_perceptron_learn;

  localparam int N  = 8;
  localparam int WW = 8;
  localparam int AW = 12;

  typedef struct {
    int net;
    bit res;
    int cyc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0]         x;
  logic signed [AW-1:0] threshold;
  logic                 train_en;
  logic                 target;
  logic [WW-2:0]        rate;
  logic                 w_load;
  logic [2:0]           w_idx;
  logic [WW-1:0]        w_data;
  logic                 out_valid;
  logic                 result;
  logic signed [AW-1:0] net;
  logic                 busy;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cycle_cnt   = 0;
  int   w_model [N];
  int   last_busy_len;
  exp_t sb [$];

  perceptron_learn #(.N(N), .WW(WW), .AW(AW), .W_INIT(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .threshold (threshold),
    .train_en  (train_en),
    .target    (target),
    .rate      (rate),
    .w_load    (w_load),
    .w_idx     (w_idx),
    .w_data    (w_data),
    .out_valid (out_valid),
    .result    (result),
    .net       (net),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle_cnt);
    end
  endtask

  function automatic void resetModel();
    for (int i = 0; i < N; i++) w_model[i] = 1;
  endfunction

  // Behavioural perceptron: dot product, threshold, clamped learning rule.
  function automatic void model(input logic [N-1:0] xv, input int thr, input bit tr,
                                input bit tg, input int rt, output int netv,
                                output bit res, output bit upd);
    netv = 0;
    for (int i = 0; i < N; i++) if (xv[i]) netv += w_model[i];
    res = (netv >= thr);
    upd = tr && (res != tg);
    if (upd) begin
      for (int i = 0; i < N; i++) begin
        if (xv[i]) begin
          w_model[i] = tg ? w_model[i] + rt : w_model[i] - rt;
          if (w_model[i] > 127)  w_model[i] = 127;
          if (w_model[i] < -128) w_model[i] = -128;
        end
      end
    end
  endfunction

  // Monitor: every DUT result must match the oldest queued prediction.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("net", int'(net), e.net);
        checkOutput("result", int'(result), int'(e.res));
        checkOutput("latency", cycle_cnt, e.cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [N-1:0] xv, input int thr, input bit tr,
                               input bit tg, input int rt, input bit expect_out);
    int   netv;
    bit   res;
    bit   upd;
    exp_t e;
    x         = xv;
    threshold = AW'(thr);
    train_en  = tr;
    target    = tg;
    rate      = (WW-1)'(rt);
    in_valid  = 1'b1;
    #1;
    checkOutput("in_ready_idle", int'(in_ready), 1);
    if (in_ready) begin
      model(xv, thr, tr, tg, rt, netv, res, upd);
      last_busy_len = N + 1 + (upd ? N : 0);
      if (expect_out) begin
        e.net = netv;
        e.res = res;
        e.cyc = cycle_cnt + 1 + N;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitIdle(input int expected_len);
    int n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput("busy_cycles", n, expected_len);
  endtask

  task automatic loadWeight(input int idx, input int data);
    w_idx  = 3'(idx);
    w_data = WW'(data);
    w_load = 1'b1;
    if (!busy) w_model[idx] = data;
    @(negedge clk);
    w_load = 1'b0;
  endtask

  task automatic probeWeights();
    for (int i = 0; i < N; i++) begin
      applyStimulus(N'(1) << i, 0, 1'b0, 1'b0, 0, 1'b1);
      waitIdle(last_busy_len);
    end
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    x        = '0;
    threshold = '0;
    train_en = 1'b0;
    target   = 1'b0;
    rate     = '0;
    w_load   = 1'b0;
    w_idx    = '0;
    w_data   = '0;
    resetModel();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_result", int'(result), 0);
    checkOutput("rst_net", int'(net), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);

    $display("[TB] directed classification");
    applyStimulus(8'hFF, 8, 1'b0, 1'b0, 0, 1'b1);
    waitIdle(last_busy_len);
    applyStimulus(8'h0F, 5, 1'b0, 1'b0, 0, 1'b1);
    waitIdle(last_busy_len);

    $display("[TB] training and resubmission");
    applyStimulus(8'h03, 5, 1'b1, 1'b1, 2, 1'b1);
    waitIdle(last_busy_len);
    applyStimulus(8'h03, 5, 1'b1, 1'b1, 2, 1'b1);
    waitIdle(last_busy_len);
    probeWeights();

    $display("[TB] saturation");
    loadWeight(0, 126);
    applyStimulus(8'h01, 127, 1'b1, 1'b1, 4, 1'b1);
    waitIdle(last_busy_len);
    loadWeight(0, -128);
    applyStimulus(8'h01, -200, 1'b1, 1'b0, 4, 1'b1);
    waitIdle(last_busy_len);
    applyStimulus(8'h01, 0, 1'b0, 1'b0, 0, 1'b1);
    waitIdle(last_busy_len);

    $display("[TB] host write interactions");
    applyStimulus(8'hFF, 0, 1'b0, 1'b0, 0, 1'b1);
    loadWeight(2, 50);
    checkOutput("in_ready_accum", int'(in_ready), 0);
    waitIdle(last_busy_len - 1);
    x        = 8'hFF;
    in_valid = 1'b1;
    w_idx    = 3'd3;
    w_data   = WW'(-5);
    w_load   = 1'b1;
    #1;
    checkOutput("in_ready_wload", int'(in_ready), 0);
    w_model[3] = -5;
    @(negedge clk);
    w_load   = 1'b0;
    in_valid = 1'b0;
    checkOutput("busy_after_wload", int'(busy), 0);
    probeWeights();

    $display("[TB] reset abort during accumulation");
    applyStimulus(8'hFF, 0, 1'b1, 1'b1, 9, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    resetModel();
    checkOutput("abort_in_ready", int'(in_ready), 1);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_net", int'(net), 0);
    repeat (N + 4) @(negedge clk);
    probeWeights();

    $display("[TB] randomized samples");
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        loadWeight(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)) - 128);
      end
      applyStimulus(N'($urandom), int'($urandom_range(0, 80)) - 30,
                    1'($urandom), 1'($urandom), int'($urandom_range(0, 127)), 1'b1);
      waitIdle(last_busy_len);
    end
    probeWeights();

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/perceptron_learn.md
PERCEPTRON_LEARN -- requirements
Module: perceptron_learn

Interface
REQ-001 Parameter N, default 8: number of binary inputs and weights (N >= 2).
REQ-002 Parameter WW, default 8: signed weight width.
REQ-003 Parameter AW, default WW+$clog2(N)+1: signed accumulator and threshold width.
REQ-004 Parameter W_INIT, default 1: signed reset value of every weight.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 in_valid  in  1  sample offered.
REQ-008 in_ready  out  1  block accepts a sample this cycle.
REQ-009 x  in  N  binary input vector; bit i pairs with weight i.
REQ-010 threshold  in  AW  signed activation threshold, latched with the sample.
REQ-011 train_en  in  1  sample is a training sample, latched with it.
REQ-012 target  in  1  desired result for a training sample, latched with it.
REQ-013 rate  in  WW-1  unsigned learning step, latched with the sample.
REQ-014 w_load, w_idx[$clog2(N)-1:0], w_data[WW-1:0]  in  host weight write port.
REQ-015 out_valid  out  1  one-cycle pulse; result and net valid.
REQ-016 result  out  1  classification; held until the next out_valid.
REQ-017 net  out  AW  signed weighted sum; held until the next out_valid.
REQ-018 busy  out  1  state is not IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, ACCUM, DECIDE and UPDATE.
REQ-020 in_ready SHALL be (state==IDLE) && !w_load; a sample is accepted when in_valid && in_ready.
REQ-021 On accept: latch x, threshold, train_en, target and rate; clear acc and idx; go to ACCUM.
REQ-022 ACCUM: each cycle acc += sign-extended w[idx] if x[idx] is 1, else acc is unchanged; idx++; after idx==N-1 go to DECIDE.
REQ-023 DECIDE: result <= (acc >= threshold, signed); net <= acc; pulse out_valid for one cycle.
REQ-024 Latency: a sample accepted in cycle T SHALL produce out_valid in cycle T+N+1; out_valid has no backpressure.
REQ-025 From DECIDE: if train_en is 1 and result != target, go to UPDATE with idx=0; otherwise go to IDLE.
REQ-026 UPDATE: for N cycles, when x[idx] is 1, w[idx] SHALL become w[idx]+rate if target is 1, else w[idx]-rate, saturated to the signed WW range; then go to IDLE.
REQ-027 A training sample that is classified correctly SHALL leave all weights unchanged.
REQ-028 w_load SHALL write w_data to w[w_idx] only in IDLE; it is ignored in all other states; a w_idx >= N is ignored.
REQ-029 With w_load and in_valid asserted in the same cycle, the load SHALL occur and the sample SHALL NOT be accepted.
REQ-030 acc SHALL never overflow at AW width: N*(2^(WW-1)) fits.

Reset
REQ-031 With reset low at a clock edge: state=IDLE, all weights=W_INIT, acc=0, idx=0, out_valid=0, result=0, net=0.
REQ-032 Reset asserted in any state SHALL abort the operation in progress, with no out_valid pulse and no weight update.

Structure
REQ-033 A shared package SHALL hold the FSM state enum and the default parameter values.
REQ-034 A sub-module sat_addsub (WW-bit signed add/subtract with saturation) SHALL implement the weight update.

Verification (N=8, WW=8, W_INIT=1)
REQ-035 After reset, x=8'hFF, thr=8, train_en=0, accepted at cycle T -> out_valid at T+9, net=8, result=1.
REQ-036 x=8'h0F, thr=5 -> net=4, result=0; busy is high from T+1 to T+9.
REQ-037 x=8'h03, thr=5, train_en=1, target=1, rate=2 -> result=0, w0=w1=3, others 1; resubmit the same sample -> net=6, result=1, no update.
REQ-038 Load w0=126, then x=8'h01, thr=127, train_en=1, target=1, rate=4 -> net=126, result=0, w0 saturates to 127; load w0=-128, target=0, thr=-200 -> w0 stays -128.
REQ-039 Reset low during ACCUM -> next cycle in_ready=1, no out_valid pulse, all weights=1.
REQ-040 w_load during ACCUM is ignored; w_load with in_valid in IDLE -> in_ready=0, weight written, sample not accepted.
